// File: rtl/ctrl_iprog_server.sv
// ctrl_iprog_server: holds the filter-stage program and replays it one word per
// pointer request. A program is appended while prog=1 and served cyclically
// afterwards. Each request gets exactly one word with a one-cycle iw_valid strobe.
module ctrl_iprog_server #(
   parameter int REGFILE_ADDR_WIDTH = 2,
   parameter int DATA_ADDR_WIDTH    = 4,
   parameter int PROG_SIZE          = 32,
   localparam int INSTR_W = 2 + 2*REGFILE_ADDR_WIDTH + 4*DATA_ADDR_WIDTH,
   localparam int PC_W    = $clog2(PROG_SIZE),
   localparam int LEN_W   = PC_W + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               prog,
   input  logic               wr_valid,
   input  logic [INSTR_W-1:0] wr_word,
   input  logic               ptr_req,
   output logic [INSTR_W-1:0] instr_word,
   output logic               iw_valid,
   output logic               pass,
   output logic [LEN_W-1:0]   prog_len,
   output logic               ovf
);

   typedef enum logic [2:0] {
      S_EMPTY = 3'd0,
      S_LOAD  = 3'd1,
      S_READY = 3'd2,
      S_RESP  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] PROG_SIZE_C = LEN_W'(PROG_SIZE);

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [LEN_W-1:0]     wptr_q, wptr_d;
   logic [LEN_W-1:0]     prog_len_q, prog_len_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 iw_valid_q, iw_valid_d;
   logic                 pass_q, pass_d;
   logic                 ovf_q, ovf_d;
   logic                 mem_we_s;
   logic                 last_s;
   logic [INSTR_W-1:0]   mem_q [PROG_SIZE];

   // Current pc addresses the final word of the loaded program.
   assign last_s = ({1'b0, pc_q} == (prog_len_q - LEN_W'(1)));

   // Next-state and response logic; prog=1 overrides every other activity.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      wptr_d     = wptr_q;
      prog_len_d = prog_len_q;
      instr_d    = instr_q;
      iw_valid_d = 1'b0;
      pass_d     = 1'b0;
      ovf_d      = ovf_q;
      mem_we_s   = 1'b0;
      if (prog) begin
         if (state_q != S_LOAD) begin
            // Entering load mode: restart the append pointer and clear overflow.
            state_d = S_LOAD;
            wptr_d  = {LEN_W{1'b0}};
            ovf_d   = 1'b0;
         end else if (wr_valid) begin
            if (wptr_q < PROG_SIZE_C) begin
               mem_we_s = 1'b1;
               wptr_d   = wptr_q + LEN_W'(1);
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            state_d = S_LOAD;
         end
      end else begin
         case (state_q)
            S_LOAD: begin
               prog_len_d = wptr_q;
               pc_d       = {PC_W{1'b0}};
               if (wptr_q != {LEN_W{1'b0}}) begin
                  state_d = S_READY;
               end else begin
                  state_d = S_EMPTY;
               end
            end
            S_EMPTY: begin
               state_d = S_EMPTY;
            end
            S_READY: begin
               if (ptr_req) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_READY;
               end
            end
            S_RESP: begin
               instr_d    = mem_q[pc_q];
               iw_valid_d = 1'b1;
               pass_d     = last_s;
               if (last_s) begin
                  pc_d = {PC_W{1'b0}};
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
               state_d = S_HOLD;
            end
            S_HOLD: begin
               // A held request never produces a second word.
               if (ptr_req) begin
                  state_d = S_HOLD;
               end else begin
                  state_d = S_READY;
               end
            end
            default: begin
               state_d = S_EMPTY;
            end
         endcase
      end
   end

   // State and output registers; en=0 freezes everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_EMPTY;
         pc_q       <= {PC_W{1'b0}};
         wptr_q     <= {LEN_W{1'b0}};
         prog_len_q <= {LEN_W{1'b0}};
         instr_q    <= {INSTR_W{1'b0}};
         iw_valid_q <= 1'b0;
         pass_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (en) begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         wptr_q     <= wptr_d;
         prog_len_q <= prog_len_d;
         instr_q    <= instr_d;
         iw_valid_q <= iw_valid_d;
         pass_q     <= pass_d;
         ovf_q      <= ovf_d;
      end
   end

   // Program memory: append-only writes during load, contents survive reset.
   always_ff @(posedge clk) begin
      if (rst && en && mem_we_s) begin
         mem_q[wptr_q[PC_W-1:0]] <= wr_word;
      end
   end

   // Strobes are suppressed while frozen so a pending strobe shows only once en returns.
   assign instr_word = instr_q;
   assign iw_valid   = iw_valid_q & en;
   assign pass       = pass_q & en;
   assign prog_len   = prog_len_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_ctrl_iprog_server.sv
// Directed bench for ctrl_iprog_server: reset, load, cyclic replay, overflow,
// clock-enable freeze and program abort in the response cycle.
module tb_ctrl_iprog_server;

   localparam int W = 22;

   logic          clk = 1'b0;
   logic          rst, en, prog, wr_valid, ptr_req;
   logic [W-1:0]  wr_word;
   logic [W-1:0]  instr_word;
   logic          iw_valid, pass, ovf;
   logic [5:0]    prog_len;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            ev_cnt  = 0;
   int            stray_pass = 0;
   logic [W-1:0]  last_word;
   logic          last_pass;
   logic [W-1:0]  words [0:39];

   ctrl_iprog_server dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .prog       (prog),
      .wr_valid   (wr_valid),
      .wr_word    (wr_word),
      .ptr_req    (ptr_req),
      .instr_word (instr_word),
      .iw_valid   (iw_valid),
      .pass       (pass),
      .prog_len   (prog_len),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   // Record every served word, sampled away from the active edge.
   always @(negedge clk) begin
      if (iw_valid === 1'b1) begin
         ev_cnt    = ev_cnt + 1;
         last_word = instr_word;
         last_pass = pass;
      end
      if (pass === 1'b1 && iw_valid !== 1'b1) stray_pass = stray_pass + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Load words[0..n-1]; called at a negedge, returns after prog fall has taken effect.
   task automatic load_n(input int n);
      prog = 1'b1; wr_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1; wr_word = words[i];
         @(negedge clk);
      end
      wr_valid = 1'b0; prog = 1'b0;
      @(negedge clk);
      #1;
   endtask

   // One 4-phase request: ptr_req high 3 cycles, low 2; expect exactly one word.
   task automatic req(input string tag, input logic [W-1:0] exp_word, input logic exp_pass);
      int c0;
      c0 = ev_cnt;
      ptr_req = 1'b1;
      repeat (3) @(negedge clk);
      ptr_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check({tag, " count"}, 32'(ev_cnt - c0), 32'd1);
      check({tag, " word"}, 32'(last_word), 32'(exp_word));
      check({tag, " pass"}, 32'(last_pass), 32'(exp_pass));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst = 1'b0; en = 1'b1; prog = 1'b0; wr_valid = 1'b0; wr_word = '0; ptr_req = 1'b1;

      // T1: reset, then requests in EMPTY produce nothing
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("t1 iw_valid events", 32'(ev_cnt), 32'd0);
      check("t1 prog_len", 32'(prog_len), 32'd0);
      check("t1 ovf", 32'(ovf), 32'd0);
      check("t1 instr_word", 32'(instr_word), 32'd0);
      ptr_req = 1'b0;
      @(negedge clk);

      // T2: load three words
      words[0] = 22'h2A5F08; words[1] = 22'h1003C0; words[2] = 22'h3FFFFF;
      load_n(3);
      check("t2 prog_len", 32'(prog_len), 32'd3);
      check("t2 ovf", 32'(ovf), 32'd0);

      // T3: four requests, wrap after third
      req("t3 r0", 22'h2A5F08, 1'b0);
      req("t3 r1", 22'h1003C0, 1'b0);
      req("t3 r2", 22'h3FFFFF, 1'b1);
      req("t3 r3", 22'h2A5F08, 1'b0);

      // T4: 33 writes into 32-word memory
      for (int i = 0; i < 33; i++) words[i] = W'(32'h150000 + i * 32'h111);
      load_n(33);
      check("t4 prog_len", 32'(prog_len), 32'd32);
      check("t4 ovf", 32'(ovf), 32'd1);
      for (int i = 0; i < 33; i++) begin
         req($sformatf("t4 r%0d", i), words[i % 32], (i == 31) ? 1'b1 : 1'b0);
      end

      // T5: freeze right after request accepted; pc now 1
      c0 = ev_cnt;
      ptr_req = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("t5 no strobe while frozen", 32'(ev_cnt - c0), 32'd0);
      en = 1'b1;
      @(negedge clk);
      #1;
      check("t5 strobe first enabled cycle", 32'(ev_cnt - c0), 32'd1);
      check("t5 word", 32'(last_word), 32'(words[1]));
      repeat (2) @(negedge clk);
      ptr_req = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("t5 single strobe", 32'(ev_cnt - c0), 32'd1);

      // T6: prog rises in the RESP cycle; pc now 2
      c0 = ev_cnt;
      ptr_req = 1'b1;
      @(negedge clk);
      prog = 1'b1;
      @(negedge clk);
      #1;
      check("t6 iw_valid aborted", 32'(iw_valid), 32'd0);
      check("t6 ovf cleared", 32'(ovf), 32'd0);
      ptr_req = 1'b0;
      wr_valid = 1'b1; wr_word = 22'h155555;
      @(negedge clk);
      wr_valid = 1'b0; prog = 1'b0;
      @(negedge clk);
      #1;
      check("t6 no response", 32'(ev_cnt - c0), 32'd0);
      check("t6 prog_len", 32'(prog_len), 32'd1);
      req("t6 r0", 22'h155555, 1'b1);
      req("t6 r1", 22'h155555, 1'b1);
      req("t6 r2", 22'h155555, 1'b1);

      check("stray pass", 32'(stray_pass), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
